mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4-to-1 mux between four requesters.
- Grants exactly one requester at a time.
- Drives the mux select lines s1/s0 for the granted requester and holds them for the whole grant.
- Sits in front of the combinational mux4to1 and sequences which input reaches `out`.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles per owner; used only when RR_ARB_TIMEOUT_EN is defined; legal range 1..255.
- START_PTR, 0: priority pointer value loaded at reset; legal range 0..3.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request vector; bit i = requester i wants the mux; must stay high for the duration of the grant.
- gnt  output  4  one-hot grant vector; all zero when idle.
- s1  output  1  mux select MSB; equals owner index bit 1.
- s0  output  1  mux select LSB; equals owner index bit 0.
- valid  output  1  high while a grant is active (mux output meaningful).

Behaviour:
- Reset (rst=1 at a clock edge, overrides all other inputs):
  - state=IDLE, gnt=4'b0000, s1=0, s0=0, valid=0, ptr=START_PTR, hold counter=0.
  - Reset mid-grant drops the grant on that same edge, with no release cycle.
- State machine has two states, IDLE and GRANT. All outputs are registered.
- IDLE:
  - If req==0, remain in IDLE.
  - Otherwise select winner w = first set bit of req searching ptr, ptr+1, ... modulo 4 (wraps 3->0).
  - On the next edge: gnt=1<<w, {s1,s0}=w, valid=1, state=GRANT.
  - Latency from req sampled high to gnt high is 1 cycle.
- GRANT:
  - Owner o keeps the grant while req[o]=1.
  - Requests from other bits are ignored; no preemption.
  - When req[o] is sampled 0: on the next edge gnt=0, valid=0, ptr=(o+1) mod 4, state=IDLE.
- Idle gap:
  - At least one IDLE cycle always separates two grants.
  - gnt never changes owner in a single edge.
- Select retention: s1/s0 keep the last owner's index while IDLE and change only when a new grant is issued. This avoids needless mux toggling.
- Simultaneous requests: resolved by the rotating pointer only; no fixed priority beyond START_PTR at reset.
- Invariants:
  - gnt is always zero or one-hot.
  - valid == |gnt.
  - When valid=1, {s1,s0} equals the index of the set gnt bit.
- Starvation bound, without the optional feature: any requester holding req high is granted after at most 3 other complete grants.

Optional Feature:
- Macro: RR_ARB_TIMEOUT_EN.
- When defined:
  - An 8-bit hold counter clears on each new grant and increments every GRANT cycle.
  - When the counter reaches MAX_HOLD with req[o] still 1, a release is forced exactly like a normal release: gnt=0, valid=0, ptr=o+1.
  - The owner must re-arbitrate; if it is the only requester it is re-granted after the one IDLE cycle.
  - Worst-case wait per requester is 3*(MAX_HOLD+1) cycles.
- When undefined: no counter is instantiated, and a grant is held indefinitely while req[o]=1.

Decomposition:
- Package mux4_arb_pkg:
  - NUM_REQ=4 and SEL_W=2.
  - State encoding localparams ST_IDLE=1'b0 and ST_GRANT=1'b1.
  - HOLD_CNT_W=8.
- Sub-module rr_pick4: purely combinational rotating-priority picker.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: any (1), idx[1:0].
- Top module contains the FSM, pointer, output registers and optional counter.

Test Plan:
- Reset: rst=1 for 2 cycles with req=4'b1111 -> gnt=0000, valid=0, s1s0=00. After release with START_PTR=0 -> gnt=0001 one cycle later, s1s0=00.
- Round-robin rotation: req=1111 held, each owner drops its req for 1 cycle after 2 grant cycles -> grant order 0,1,2,3,0. One IDLE cycle between grants. s1s0 sequence 00,01,10,11,00.
- Wrap and skip: ptr=3 after owner 2 releases, req=0101 -> next winner is 0 (gnt=0001, s1s0=00), not 2.
- Select retention and no preemption: owner 1 granted, req[3] rises mid-grant -> gnt stays 0010. After release, valid=0 with s1s0=01 retained for the IDLE cycle, then gnt=1000, s1s0=11.
- Reset mid-grant: gnt=0100, rst=1 for one edge -> next cycle gnt=0000, valid=0, s1s0=00, ptr=START_PTR.
- Timeout (RR_ARB_TIMEOUT_EN, MAX_HOLD=4): req=0011 held high continuously -> owner 0 gets 4 grant cycles, 1 IDLE, owner 1 gets 4 grant cycles, 1 IDLE, owner 0 again. Without the macro, owner 0 holds indefinitely.

Source files
------------

// File: rtl/mux4_arb_pkg.sv
// Shared constants and state type for the 4-way round-robin mux arbiter.
package mux4_arb_pkg;
  localparam int NUM_REQ    = 4;
  localparam int SEL_W      = 2;
  localparam int HOLD_CNT_W = 8;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  typedef enum logic {
    IDLE  = ST_IDLE,
    GRANT = ST_GRANT
  } arb_state_e;
endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: first set req bit at ptr, ptr+1, ... (mod 4).
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  // Walk from the farthest offset back to ptr so the nearest set bit wins.
  always_comb begin
    any = 1'b0;
    idx = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[ptr + SEL_W'(k)]) begin
        any = 1'b1;
        idx = ptr + SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the s1/s0 selects of a shared 4:1 mux.
// Optional forced release after MAX_HOLD grant cycles when RR_ARB_TIMEOUT_EN is defined.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int MAX_HOLD  = 8,
  parameter int START_PTR = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               s1,
  output logic               s0,
  output logic               valid
);

  arb_state_e         state, state_n;
  logic [SEL_W-1:0]   ptr, ptr_n;
  logic [SEL_W-1:0]   sel, sel_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic               valid_n;
  logic               pick_any;
  logic [SEL_W-1:0]   pick_idx;
  logic               timeout;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

`ifdef RR_ARB_TIMEOUT_EN
  logic [HOLD_CNT_W-1:0] hold;

  // Counts completed grant cycles; sitting at zero in IDLE gives a fresh count per grant.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) hold <= '0;
    else                      hold <= hold + 1'b1;
  end

  assign timeout = (state == GRANT) && ((hold + 1'b1) >= HOLD_CNT_W'(MAX_HOLD));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = sel;
    gnt_n   = gnt;
    valid_n = valid;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_n = GRANT;
          sel_n   = pick_idx;
          gnt_n   = NUM_REQ'(1) << pick_idx;
          valid_n = 1'b1;
        end
      end
      GRANT: begin
        // sel holds the owner index for the whole grant.
        if (!req[sel] || timeout) begin
          state_n = IDLE;
          gnt_n   = '0;
          valid_n = 1'b0;
          ptr_n   = sel + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= SEL_W'(START_PTR);
      sel   <= '0;
      gnt   <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      sel   <= sel_n;
      gnt   <= gnt_n;
      valid <= valid_n;
    end
  end

  assign s1 = sel[1];
  assign s0 = sel[0];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench: driver runs a behavioural arbiter model and queues per-cycle expectations.
module tb_mux4_rr_arbiter;
  localparam int MAX_HOLD  = 4;
  localparam int START_PTR = 0;
`ifdef RR_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic       s1, s0, valid;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .START_PTR(START_PTR)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .gnt   (gnt),
    .s1    (s1),
    .s0    (s0),
    .valid (valid)
  );

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
  } exp_t;

  exp_t q[$];
  int compared   = 0;
  int mismatched = 0;

  // Model state: owner index (-1 = idle), pointer, retained select, grant cycles so far.
  int m_owner = -1;
  int m_ptr   = START_PTR;
  int m_sel   = 0;
  int m_hold  = 0;

  task automatic check(input string name, input int act, input int req_v);
    compared++;
    if (act != req_v) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req_v);
    end
  endtask

  // Apply one cycle of inputs and predict the outputs after the following edge.
  task automatic step(input logic [3:0] r, input logic rr);
    exp_t e;
    @(negedge clk);
    req = r;
    rst = rr;
    if (rr) begin
      m_owner = -1; m_ptr = START_PTR; m_sel = 0; m_hold = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          m_sel   = m_owner;
          m_hold  = 0;
        end
      end
    end else if (!r[m_owner] || (TIMEOUT_ON && m_hold + 1 >= MAX_HOLD)) begin
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
    end else begin
      m_hold++;
    end
    e.gnt   = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    e.sel   = 2'(m_sel);
    e.valid = (m_owner >= 0);
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("gnt",   int'(gnt),       int'(e.gnt));
        check("sel",   int'({s1, s0}),  int'(e.sel));
        check("valid", int'(valid),     int'(e.valid));
      end
    end
  end

  initial begin
    logic [3:0] r;
    repeat (2) step(4'b1111, 1'b1);
    // Rotation: each owner drops its request after two grant cycles.
    for (int i = 0; i < 24; i++) begin
      r = 4'b1111;
      if (m_owner >= 0 && m_hold >= 1) r[m_owner] = 1'b0;
      step(r, 1'b0);
    end
    // No preemption while owner 1 holds; then owner 3 after the idle gap.
    repeat (3) step(4'b0010, 1'b0);
    repeat (3) step(4'b1010, 1'b0);
    repeat (4) step(4'b1000, 1'b0);
    repeat (2) step(4'b0000, 1'b0);
    // Owner 2 releases, pointer lands on 3, 0101 must pick 0.
    repeat (3) step(4'b0100, 1'b0);
    step(4'b0001, 1'b0);
    repeat (3) step(4'b0101, 1'b0);
    repeat (2) step(4'b0000, 1'b0);
    // Reset in the middle of a grant.
    repeat (3) step(4'b0100, 1'b0);
    step(4'b0100, 1'b1);
    repeat (2) step(4'b0000, 1'b0);
    // Continuous two-way contention: timeout alternates owners, otherwise owner 0 keeps it.
    repeat (30) step(4'b0011, 1'b0);
    // Randomized sticky requests with occasional reset.
    r = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      r = r ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      step(r, ($urandom_range(0, 99) == 0));
    end
    repeat (3) step(4'b0000, 1'b0);
    repeat (2) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
